// File: rtl/riscv_trace_pkg.sv
// Shared types and constants for the commit-trace capture buffer.
// The entry layout is fixed here; the top-level DATA_W/ADDR_W parameters
// are expected to match TR_DATA_W/TR_ADDR_W.
package riscv_trace_pkg;

  localparam int STAMP_W   = 16;
  localparam int OVF_W     = 16;
  localparam int TR_DATA_W = 32;
  localparam int TR_ADDR_W = 9;

  // Flag bit positions inside trace_entry_t.flags
  localparam int TR_REG_WE = 0;
  localparam int TR_MEM_WR = 1;
  localparam int TR_MEM_RD = 2;

  typedef struct packed {
    logic [2:0]           flags;     // {mem_rd, mem_wr, reg_we}
    logic [4:0]           reg_num;
    logic [TR_DATA_W-1:0] reg_data;
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] mem_data;
    logic [STAMP_W-1:0]   stamp;
  } trace_entry_t;

endpackage

// File: rtl/riscv_trace_buffer_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head.
// The caller qualifies push/pop: pop only when not empty, push only when
// not full or when popping in the same cycle.
module trace_fifo #(
  parameter type T         = logic,
  parameter int  DEPTH     = 16,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  T                 head_reg;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_reg;

  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign count      = count_reg;
  assign head       = head_reg;

  // Storage array: write-only port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head (synchronous read of next slot)
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
      head_reg  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        // With a single entry left, the next head can only be the incoming word
        if (count_reg == CNT_W'(1)) begin
          head_reg <= push ? din : '0;
        end else begin
          head_reg <= mem[rd_ptr_inc];
        end
      end else if (empty && push) begin
        head_reg <= din;
      end
    end
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Commit-trace capture: packs each active core cycle into one entry and
// buffers it; drops (counted, sticky flag) when full instead of stalling.
// Optional feature macro: RISCV_TRACE_STAMP_EN adds a 16-bit cycle stamp.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output trace_entry_t           trace_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   overflow
);

  logic               reg_we;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [STAMP_W-1:0] stamp_now;
  trace_entry_t       entry;
  logic [OVF_W-1:0]   ovf_cnt_reg;
  logic               ovf_reg;

`ifdef RISCV_TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_reg;

  // Free-running cycle counter; entries take its value at the capture edge
  always_ff @(posedge clk) begin
    if (reset) stamp_reg <= '0;
    else       stamp_reg <= stamp_reg + 1'b1;
  end
  assign stamp_now = stamp_reg;
`else
  assign stamp_now = '0;
`endif

  // Event qualification and entry packing; unused fields are zeroed
  always_comb begin
    reg_we   = reg_write_sig && (reg_num != 5'd0);
    push_req = reg_we || wr || rd;
    entry    = '0;
    entry.flags[TR_REG_WE] = reg_we;
    entry.flags[TR_MEM_WR] = wr;
    entry.flags[TR_MEM_RD] = rd;
    if (reg_we) begin
      entry.reg_num  = reg_num;
      entry.reg_data = TR_DATA_W'(reg_data);
    end
    if (wr || rd) begin
      entry.addr = TR_ADDR_W'(addr);
    end
    if (wr) begin
      entry.mem_data = TR_DATA_W'(wr_data);
    end else if (rd) begin
      entry.mem_data = TR_DATA_W'(rd_data);
    end
    entry.stamp = stamp_now;
  end

  assign trace_valid = !empty;
  assign pop         = trace_valid && trace_ready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign push        = push_req && (!full || pop);

  trace_fifo #(
    .T     (trace_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .head  (trace_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Drop accounting: saturating counter plus sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_reg <= '0;
      ovf_reg     <= 1'b0;
    end else if (push_req && !push) begin
      ovf_reg <= 1'b1;
      if (ovf_cnt_reg != '1) ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
    end
  end

  assign overflow_cnt = ovf_cnt_reg;
  assign overflow     = ovf_reg;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer: queue-based reference model
// compared every cycle, plus hand-computed literal checks.
module tb_riscv_trace_buffer;
  import riscv_trace_pkg::*;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         reg_write_sig;
  logic [4:0]   reg_num;
  logic [31:0]  reg_data;
  logic         wr;
  logic         rd;
  logic [8:0]   addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic         trace_valid;
  logic         trace_ready;
  trace_entry_t trace_entry;
  logic [4:0]   count;
  logic [15:0]  overflow_cnt;
  logic         overflow;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.DATA_W(32), .ADDR_W(9), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .reg_write_sig (reg_write_sig),
    .reg_num       (reg_num),
    .reg_data      (reg_data),
    .wr            (wr),
    .rd            (rd),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .trace_valid   (trace_valid),
    .trace_ready   (trace_ready),
    .trace_entry   (trace_entry),
    .count         (count),
    .overflow_cnt  (overflow_cnt),
    .overflow      (overflow)
  );

  // Reference model state
  trace_entry_t exp_q[$];
  int           m_ovf      = 0;
  bit           m_ovf_flag = 1'b0;
  int           m_stamp    = 0;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Entry as the rules describe it, built from the current input values
  function automatic trace_entry_t model_entry();
    trace_entry_t e;
    bit we;
    we = reg_write_sig && (reg_num != 0);
    e = '0;
    e.flags = {rd, wr, we};
    if (we) begin
      e.reg_num  = reg_num;
      e.reg_data = reg_data;
    end
    if (wr || rd) e.addr = addr;
    e.mem_data = wr ? wr_data : (rd ? rd_data : 32'h0);
`ifdef RISCV_TRACE_STAMP_EN
    e.stamp = 16'(m_stamp);
`endif
    return e;
  endfunction

  // Advance the model by one clock edge
  task automatic model_edge();
    bit ev;
    if (reset) begin
      exp_q.delete();
      m_ovf = 0;
      m_ovf_flag = 1'b0;
      m_stamp = 0;
      return;
    end
    ev = (reg_write_sig && reg_num != 0) || wr || rd;
    if (exp_q.size() != 0 && trace_ready) void'(exp_q.pop_front());
    if (ev) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(model_entry());
      end else begin
        if (m_ovf < 65535) m_ovf++;
        m_ovf_flag = 1'b1;
      end
    end
    m_stamp = (m_stamp + 1) % 65536;
  endtask

  // Per-cycle comparison of every output against the model
  task automatic compare_outputs();
    chk("count", 128'(count), 128'(exp_q.size()));
    chk("valid", 128'(trace_valid), 128'(exp_q.size() != 0));
    chk("ovf_cnt", 128'(overflow_cnt), 128'(m_ovf));
    chk("ovf_flag", 128'(overflow), 128'(m_ovf_flag));
    if (exp_q.size() != 0) chk("head", 128'(trace_entry), 128'(exp_q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic set_ev(input bit rws, input logic [4:0] rn, input logic [31:0] rdat,
                        input bit w, input bit r, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] rdd);
    reg_write_sig = rws;
    reg_num       = rn;
    reg_data      = rdat;
    wr            = w;
    rd            = r;
    addr          = a;
    wr_data       = wd;
    rd_data       = rdd;
  endtask

  task automatic idle();
    set_ev(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    trace_ready = 1'b0;
    idle();
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 128'(trace_valid), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_entry", 128'(trace_entry), 128'(0));
    chk("rst_ovf", 128'(overflow_cnt), 128'(0));

    // Single register write
    trace_ready = 1'b1;
    set_ev(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    step();
    idle();
    chk("t1_valid", 128'(trace_valid), 128'(1));
    chk("t1_flags", 128'(trace_entry.flags), 128'(3'b001));
    chk("t1_regnum", 128'(trace_entry.reg_num), 128'(5));
    chk("t1_regdata", 128'(trace_entry.reg_data), 128'(32'hDEADBEEF));
    step();
    chk("t1_drained", 128'(count), 128'(0));

    // Write to x0 only: not traced
    set_ev(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    step();
    idle();
    chk("x0_count", 128'(count), 128'(0));
    chk("x0_valid", 128'(trace_valid), 128'(0));

    // Register write with store and load in the same cycle
    set_ev(1'b1, 5'd7, 32'hAAAA5555, 1'b1, 1'b1, 9'h1F0, 32'h12, 32'h99);
    step();
    idle();
    chk("t3_flags", 128'(trace_entry.flags), 128'(3'b111));
    chk("t3_memdata", 128'(trace_entry.mem_data), 128'(32'h12));
    chk("t3_addr", 128'(trace_entry.addr), 128'(9'h1F0));
    step();

    // Load only, register write disabled: register fields zeroed
    set_ev(1'b0, 5'd3, 32'hFFFF0000, 1'b0, 1'b1, 9'h0A4, 32'h55, 32'h77);
    step();
    idle();
    chk("ld_flags", 128'(trace_entry.flags), 128'(3'b100));
    chk("ld_memdata", 128'(trace_entry.mem_data), 128'(32'h77));
    chk("ld_regdata", 128'(trace_entry.reg_data), 128'(0));
    step();

    // 20 events with no consumer: 16 kept, 4 dropped
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ev(1'b1, 5'((i % 31) + 1), 32'(i + 1), 1'(i % 2), 1'b0, 9'(i * 4),
             32'(i * 3), 32'h0);
      step();
    end
    idle();
    step();
    chk("ovf_count", 128'(count), 128'(16));
    chk("ovf_cnt", 128'(overflow_cnt), 128'(4));
    chk("ovf_sticky", 128'(overflow), 128'(1));
    chk("ovf_head", 128'(trace_entry.reg_data), 128'(1));
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("drain_empty", 128'(count), 128'(0));

    // Refill to full, then push and pop together
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_ev(1'b1, 5'd9, 32'h100 + 32'(i), 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
      step();
    end
    chk("refill_full", 128'(count), 128'(16));
    trace_ready = 1'b1;
    set_ev(1'b1, 5'd10, 32'hCAFE, 1'b1, 1'b0, 9'h33, 32'h44, 32'h0);
    step();
    chk("pp_count", 128'(count), 128'(16));
    chk("pp_ovf", 128'(overflow_cnt), 128'(4));
    idle();
    for (int i = 0; i < 8; i++) step();
    trace_ready = 1'b0;
    chk("pend8", 128'(count), 128'(8));

    // Reset while 8 entries pending, with an event on the reset cycle
    reset = 1'b1;
    trace_ready = 1'b1;
    set_ev(1'b1, 5'd2, 32'h5A5A, 1'b1, 1'b0, 9'h11, 32'h22, 32'h0);
    step();
    reset = 1'b0;
    idle();
    chk("mrst_valid", 128'(trace_valid), 128'(0));
    chk("mrst_count", 128'(count), 128'(0));
    chk("mrst_ovf", 128'(overflow_cnt), 128'(0));
    chk("mrst_flag", 128'(overflow), 128'(0));
    step();
    set_ev(1'b1, 5'd4, 32'h77, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    trace_ready = 1'b0;
    step();
    idle();
`ifdef RISCV_TRACE_STAMP_EN
    chk("stamp", 128'(trace_entry.stamp), 128'(1));
`else
    chk("stamp", 128'(trace_entry.stamp), 128'(0));
`endif
    trace_ready = 1'b1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Commit-trace capture stage downstream of the `riscv` core. It samples the core's debug outputs every cycle: register-file writes (`reg_write_sig`/`reg_num`/`reg_data`) and data-memory accesses (`wr`/`rd`/`addr`/`wr_data`/`rd_data`). Each active cycle is packed into one trace entry and buffered in a small synchronous FIFO. A host or testbench drains the FIFO through a valid/ready port. Overflow is counted rather than back-pressuring the core, which cannot be stalled.

## Interface
- `DATA_W`, 32, data width of register and memory data
- `ADDR_W`, 9, memory address width; matches the core's `addr`
- `DEPTH`, 16, FIFO entries; must be a power of two, minimum 2
- `clk`  in  1  clock
- `reset`  in  1  reset; synchronous, active-high
- `reg_write_sig`  in  1  core register-file write enable
- `reg_num`  in  5  destination register
- `reg_data`  in  DATA_W  register write data
- `wr`  in  1  memory write strobe
- `rd`  in  1  memory read strobe
- `addr`  in  ADDR_W  memory address
- `wr_data`  in  DATA_W  memory write data
- `rd_data`  in  DATA_W  memory read data
- `trace_valid`  out  1  head entry available
- `trace_ready`  in  1  consumer accepts head entry
- `trace_entry`  out  `trace_entry_t`  head entry: flags[2:0] {mem_rd, mem_wr, reg_we}, reg_num, reg_data, addr, mem_data, stamp[15:0]
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `overflow_cnt`  out  16  dropped entries; saturates at 16'hFFFF
- `overflow`  out  1  sticky; set on the first drop

## Operation
- Event qualifiers:
  - reg_we = `reg_write_sig && reg_num != 0` (writes to x0 are not traced)
  - mem_wr = `wr`
  - mem_rd = `rd`
- Push occurs when any qualifier is 1. One entry per cycle holds all simultaneous events.
- Entry fields:
  - `mem_data` = `wr_data` if `wr`, else `rd_data` if `rd`, else 0
  - `reg_num`/`reg_data` are zeroed when reg_we=0
  - `addr` is zeroed when neither `wr` nor `rd` is set
- Pop occurs when `trace_valid && trace_ready`.
- Push acceptance: accepted when `count < DEPTH`, or when `count == DEPTH` and a pop happens in the same cycle. Otherwise the entry is dropped: `overflow_cnt` increments (saturating) and `overflow` sets.
- Push and pop in the same cycle: `count` is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; `count` disambiguates full from empty.
- `trace_valid` = (`count != 0`). `trace_entry` is the registered head, first-word-fall-through.
- Reset:
  - `count`, pointers, `overflow_cnt`, `overflow` and the stamp counter are set to 0
  - `trace_valid`=0, `trace_entry`=0
  - An event on the reset cycle is not captured.

## Timing
- Event sampled at rising edge N → `trace_valid` high and entry visible after edge N (cycle N+1) when the FIFO was empty.
- Pop at edge N → next entry (or `trace_valid`=0) visible in cycle N+1.
- Throughput is one push and one pop per cycle.
- `count`, `overflow_cnt` and `overflow` update on the same edge as the push or pop.
- Reset mid-drain discards all contents. `trace_ready` is ignored during reset.

## Configuration
- `RISCV_TRACE_STAMP_EN` defined:
  - A 16-bit free-running cycle counter (reset to 0, wraps at 16'hFFFF→0) is instantiated.
  - Its value at the capture edge is stored in `stamp`.
- Not defined: the counter is absent and `stamp` is constant 0. All other behaviour is identical.

## Structure
- Package `riscv_trace_pkg`:
  - `trace_entry_t` packed struct
  - flag bit index constants `TR_REG_WE=0`, `TR_MEM_WR=1`, `TR_MEM_RD=2`
  - `STAMP_W=16`, `OVF_W=16`
- Sub-module `trace_fifo`: generic synchronous FWFT FIFO parameterised on element type and `DEPTH`, with push/pop/count/full/empty.
- Top handles entry packing, acceptance, the overflow counter and the stamp counter.

## Test plan
- Single register write: `reg_write_sig`=1, `reg_num`=5, `reg_data`=0xDEADBEEF, `trace_ready`=1 → one entry, flags=3'b001, next cycle; `count` returns to 0.
- Write to x0 with no memory activity → no push; `count` stays 0.
- Store and load in the same cycle as a register write: `wr`=1, `addr`=0x1F0, `wr_data`=0x12 plus `rd`=1 → flags=3'b111, `mem_data`=0x12.
- `trace_ready`=0, 20 consecutive events with `DEPTH`=16 → `count`=16, `overflow_cnt`=4, `overflow`=1. Drain yields the first 16 events in order.
- Full FIFO with a push and a pop in the same cycle → push accepted, `count` stays 16, `overflow_cnt` unchanged.
- Reset asserted while 8 entries are pending → next cycle `trace_valid`=0, `count`=0, `overflow_cnt`=0. With `RISCV_TRACE_STAMP_EN`, the first post-reset event carries `stamp`=1 when it occurs one cycle after reset release.
